// File: rtl/frame_ecc_reader_if.sv
// rtl/frame_ecc_reader_if.sv - frame-store read/write port bundle for the ECC scrubber
interface frame_ecc_reader_if #(
    parameter int ADDR_W = 7
) ();
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [38:0]       rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [38:0]       wr_data;
    logic              wr_ack;

    // Scrubber side: issues requests, receives acks and read data.
    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_ack, rd_data, wr_ack
    );

    // Frame-store side.
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_ack, rd_data, wr_ack
    );
endinterface

// File: rtl/frame_ecc_reader.sv
// rtl/frame_ecc_reader.sv - SECDED(39,32) frame-store scrubber with write-back of single-bit errors
module frame_ecc_reader #(
    parameter int NUM_FRAMES      = 16,
    parameter int WORDS_PER_FRAME = 8,
    parameter int ADDR_W          = 7,
    parameter int TIMEOUT_CYC     = 255,
    parameter int CNT_W           = 16
) (
    input  logic                 clk_100mhz,
    input  logic                 rst_n,
    input  logic                 scrub_start,
    frame_ecc_reader_if.master   store,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt,
    output logic                 err_valid,
    output logic [ADDR_W-1:0]    err_addr,
    output logic                 timeout_err,
    output logic                 overrun
);

    localparam int                TOTAL     = NUM_FRAMES * WORDS_PER_FRAME;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYC + 1);
    // The abort fires on the cycle the wait count would reach TIMEOUT_CYC.
    localparam logic [WAIT_W-1:0] TMO_LAST  = WAIT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CHK,
        S_WR,
        S_NXT,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [38:0]       word_q;

    logic [5:0]        syn;
    logic              par;
    logic              clean;
    logic              correctable;
    logic [38:0]       fixed_word;

    // Decode the captured codeword: syndrome over positions 1..38 and overall parity.
    // Flipping bit 'syn' also covers the bit-0 case because syn is 0 there.
    always_comb begin
        syn = '0;
        for (int i = 1; i < 39; i++) begin
            if (word_q[i]) begin
                syn = syn ^ 6'(i);
            end
        end
        par         = ^word_q;
        clean       = (syn == 6'd0) && !par;
        correctable = par && (syn <= 6'd38);
        fixed_word  = word_q ^ (39'd1 << syn);
    end

    // Scrub sequencer: walks every word, classifies it, writes back fixable ones.
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr          <= '0;
            wait_cnt      <= '0;
            word_q        <= '0;
            store.rd_req  <= 1'b0;
            store.rd_addr <= '0;
            store.wr_req  <= 1'b0;
            store.wr_addr <= '0;
            store.wr_data <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            corr_cnt      <= '0;
            uncorr_cnt    <= '0;
            err_valid     <= 1'b0;
            err_addr      <= '0;
            timeout_err   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            // Any start outside IDLE (DONE included) is dropped but remembered.
            if (scrub_start && state != S_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (scrub_start) begin
                        corr_cnt      <= '0;
                        uncorr_cnt    <= '0;
                        err_valid     <= 1'b0;
                        err_addr      <= '0;
                        timeout_err   <= 1'b0;
                        overrun       <= 1'b0;
                        addr          <= '0;
                        busy          <= 1'b1;
                        store.rd_req  <= 1'b1;
                        store.rd_addr <= '0;
                        wait_cnt      <= '0;
                        state         <= S_RD;
                    end
                end

                S_RD: begin
                    if (store.rd_ack) begin
                        store.rd_req <= 1'b0;
                        word_q       <= store.rd_data;
                        state        <= S_CHK;
                    end else if (wait_cnt == TMO_LAST) begin
                        store.rd_req <= 1'b0;
                        timeout_err  <= 1'b1;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_CHK: begin
                    if (clean) begin
                        state <= S_NXT;
                    end else if (correctable) begin
                        if (corr_cnt != '1) begin
                            corr_cnt <= corr_cnt + CNT_W'(1);
                        end
                        store.wr_req  <= 1'b1;
                        store.wr_addr <= addr;
                        store.wr_data <= fixed_word;
                        wait_cnt      <= '0;
                        state         <= S_WR;
                    end else begin
                        if (uncorr_cnt != '1) begin
                            uncorr_cnt <= uncorr_cnt + CNT_W'(1);
                        end
                        if (!err_valid) begin
                            err_valid <= 1'b1;
                            err_addr  <= addr;
                        end
                        state <= S_NXT;
                    end
                end

                S_WR: begin
                    if (store.wr_ack) begin
                        store.wr_req <= 1'b0;
                        state        <= S_NXT;
                    end else if (wait_cnt == TMO_LAST) begin
                        store.wr_req <= 1'b0;
                        timeout_err  <= 1'b1;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_NXT: begin
                    if (addr == LAST_ADDR) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        addr          <= addr + ADDR_W'(1);
                        store.rd_req  <= 1'b1;
                        store.rd_addr <= addr + ADDR_W'(1);
                        wait_cnt      <= '0;
                        state         <= S_RD;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_ecc_reader.sv
// tb/tb_frame_ecc_reader.sv - self-checking bench for frame_ecc_reader
module tb_frame_ecc_reader;

    localparam int ADDR_W = 7;
    localparam int NWORDS = 128;
    localparam int NV     = 6;

    logic              clk_100mhz = 1'b0;
    logic              rst_n;
    logic              scrub_start;
    logic              busy;
    logic              done;
    logic [15:0]       corr_cnt;
    logic [15:0]       uncorr_cnt;
    logic              err_valid;
    logic [ADDR_W-1:0] err_addr;
    logic              timeout_err;
    logic              overrun;

    always #5 clk_100mhz = ~clk_100mhz;

    frame_ecc_reader_if #(.ADDR_W(ADDR_W)) bus ();

    frame_ecc_reader #(
        .NUM_FRAMES     (16),
        .WORDS_PER_FRAME(8),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYC    (255),
        .CNT_W          (16)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .scrub_start(scrub_start),
        .store      (bus),
        .busy       (busy),
        .done       (done),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .err_valid  (err_valid),
        .err_addr   (err_addr),
        .timeout_err(timeout_err),
        .overrun    (overrun)
    );

    typedef struct {
        int          addr_a;
        logic [38:0] mask_a;
        int          addr_b;
        logic [38:0] mask_b;
        int          hold;
        int          exp_reads;
        int          exp_writes;
        int          exp_corr;
        int          exp_unc;
        int          exp_ev;
        int          exp_ea;
        int          exp_to;
        int          exp_bad;
        int          exp_wa;
        int          exp_hold;
    } vec_t;

    vec_t        vecs[NV];
    logic [38:0] mem[NWORDS];
    logic [38:0] orig[NWORDS];

    int n_vec  = 0;
    int n_miss = 0;
    int hold_rd = -1;
    bit hold_wr = 1'b0;
    int rd_cnt, wr_cnt, done_cnt, hold_cycles, last_wr_addr, first_rd_addr;

    // Reference SECDED encoder: data into non-power-of-two positions, then parities.
    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] c;
        logic        pbit;
        int          k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 6; b++) begin
            pbit = 1'b0;
            for (int pos = 1; pos <= 38; pos++) begin
                if (((pos >> b) & 1) == 1) pbit = pbit ^ c[pos];
            end
            c[1 << b] = pbit;
        end
        c[0] = ^c[38:1];
        return c;
    endfunction

    // Frame-store model: acks each request on the first falling edge it is seen.
    always @(negedge clk_100mhz) begin
        if (done) done_cnt++;
        if (bus.rd_req && int'(bus.rd_addr) == hold_rd) hold_cycles++;
        if (rst_n && bus.rd_req && !bus.rd_ack && int'(bus.rd_addr) != hold_rd) begin
            if (first_rd_addr < 0) first_rd_addr = int'(bus.rd_addr);
            bus.rd_data = mem[bus.rd_addr];
            bus.rd_ack  = 1'b1;
            rd_cnt++;
        end else begin
            bus.rd_data = '0;
            bus.rd_ack  = 1'b0;
        end
        if (rst_n && bus.wr_req && !bus.wr_ack && !hold_wr) begin
            mem[bus.wr_addr] = bus.wr_data;
            last_wr_addr     = int'(bus.wr_addr);
            bus.wr_ack       = 1'b1;
            wr_cnt++;
        end else begin
            bus.wr_ack = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic init_store();
        for (int i = 0; i < NWORDS; i++) begin
            orig[i] = encode((32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F);
            mem[i]  = orig[i];
        end
        rd_cnt        = 0;
        wr_cnt        = 0;
        done_cnt      = 0;
        hold_cycles   = 0;
        last_wr_addr  = -1;
        first_rd_addr = -1;
    endtask

    function automatic int count_bad();
        int n;
        n = 0;
        for (int i = 0; i < NWORDS; i++) if (mem[i] !== orig[i]) n++;
        return n;
    endfunction

    task automatic pulse_start();
        @(negedge clk_100mhz);
        scrub_start = 1'b1;
        @(negedge clk_100mhz);
        scrub_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 4000 && done_cnt < target; i++) @(negedge clk_100mhz);
        check("done_seen", 64'(done_cnt >= target), 64'd1);
        repeat (4) @(negedge clk_100mhz);
    endtask

    initial begin
        rst_n       = 1'b0;
        scrub_start = 1'b0;

        vecs[0] = '{-1, 39'h0, -1, 39'h0, -1, 128, 0, 0, 0, 0, 0, 0, 0, -1, 0};
        vecs[1] = '{'h25, 39'h1 << 13, -1, 39'h0, -1, 128, 1, 1, 0, 0, 0, 0, 0, 'h25, 0};
        vecs[2] = '{'h10, 39'h1, 'h40, (39'h1 << 3) | (39'h1 << 7), -1,
                    128, 1, 1, 1, 1, 'h40, 0, 1, 'h10, 0};
        vecs[3] = '{'h7F, 39'h1 << 38, -1, 39'h0, -1, 128, 1, 1, 0, 0, 0, 0, 0, 'h7F, 0};
        vecs[4] = '{'h00, (39'h1 << 32) | (39'h1 << 16) | (39'h1 << 8),
                    'h7F, (39'h1 << 1) | (39'h1 << 2), -1,
                    128, 0, 0, 2, 1, 0, 0, 2, -1, 0};
        vecs[5] = '{'h03, 39'h1 << 20, -1, 39'h0, 5, 5, 1, 1, 0, 0, 0, 1, 0, 3, 255};

        init_store();
        repeat (3) @(negedge clk_100mhz);
        check("reset_status_zero",
              64'({busy, done, corr_cnt, uncorr_cnt, err_valid, err_addr, timeout_err, overrun}), 64'd0);
        check("reset_bus_zero", 64'({bus.rd_req, bus.wr_req, bus.rd_addr, bus.wr_addr}), 64'd0);
        check("reset_wr_data_zero", 64'(bus.wr_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_100mhz);

        for (int v = 0; v < NV; v++) begin
            init_store();
            if (vecs[v].addr_a >= 0) mem[vecs[v].addr_a] = mem[vecs[v].addr_a] ^ vecs[v].mask_a;
            if (vecs[v].addr_b >= 0) mem[vecs[v].addr_b] = mem[vecs[v].addr_b] ^ vecs[v].mask_b;
            hold_rd = vecs[v].hold;
            pulse_start();
            wait_done(1);
            check($sformatf("v%0d_reads", v), 64'(rd_cnt), 64'(vecs[v].exp_reads));
            check($sformatf("v%0d_writes", v), 64'(wr_cnt), 64'(vecs[v].exp_writes));
            check($sformatf("v%0d_corr_cnt", v), 64'(corr_cnt), 64'(vecs[v].exp_corr));
            check($sformatf("v%0d_uncorr_cnt", v), 64'(uncorr_cnt), 64'(vecs[v].exp_unc));
            check($sformatf("v%0d_err_valid", v), 64'(err_valid), 64'(vecs[v].exp_ev));
            check($sformatf("v%0d_err_addr", v), 64'(err_addr), 64'(vecs[v].exp_ea));
            check($sformatf("v%0d_timeout_err", v), 64'(timeout_err), 64'(vecs[v].exp_to));
            check($sformatf("v%0d_bad_words", v), 64'(count_bad()), 64'(vecs[v].exp_bad));
            check($sformatf("v%0d_last_wr_addr", v), 64'(last_wr_addr), 64'(vecs[v].exp_wa));
            check($sformatf("v%0d_hold_cycles", v), 64'(hold_cycles), 64'(vecs[v].exp_hold));
            check($sformatf("v%0d_done_pulses", v), 64'(done_cnt), 64'd1);
            check($sformatf("v%0d_busy_after", v), 64'({busy, bus.rd_req, bus.wr_req}), 64'd0);
            hold_rd = -1;
        end

        // Second start mid-pass: flagged as overrun, pass runs to completion once.
        init_store();
        pulse_start();
        repeat (40) @(negedge clk_100mhz);
        check("ovr_busy_mid", 64'(busy), 64'd1);
        pulse_start();
        check("ovr_flag_set", 64'(overrun), 64'd1);
        wait_done(1);
        repeat (20) @(negedge clk_100mhz);
        check("ovr_reads", 64'(rd_cnt), 64'd128);
        check("ovr_single_done", 64'(done_cnt), 64'd1);
        check("ovr_sticky", 64'(overrun), 64'd1);
        pulse_start();
        check("ovr_cleared_on_start", 64'({overrun, busy}), 64'b01);
        wait_done(2);

        // Reset while a write-back is pending: no done, next pass starts at 0.
        init_store();
        mem[2] = mem[2] ^ (39'h1 << 9);
        hold_wr = 1'b1;
        pulse_start();
        for (int i = 0; i < 200 && !bus.wr_req; i++) @(negedge clk_100mhz);
        check("rst_wr_pending", 64'({bus.wr_req, busy}), 64'b11);
        rst_n = 1'b0;
        @(negedge clk_100mhz);
        rst_n   = 1'b1;
        hold_wr = 1'b0;
        check("rst_status_zero",
              64'({busy, done, corr_cnt, uncorr_cnt, err_valid, err_addr, timeout_err, overrun}), 64'd0);
        check("rst_bus_zero", 64'({bus.rd_req, bus.wr_req, bus.rd_addr, bus.wr_addr}), 64'd0);
        repeat (10) @(negedge clk_100mhz);
        check("rst_no_done", 64'(done_cnt), 64'd0);
        rd_cnt        = 0;
        wr_cnt        = 0;
        first_rd_addr = -1;
        pulse_start();
        wait_done(1);
        check("rst_restart_addr", 64'(first_rd_addr), 64'd0);
        check("rst_restart_reads", 64'(rd_cnt), 64'd128);
        check("rst_restart_corr", 64'(corr_cnt), 64'd1);
        check("rst_restart_fixed", 64'(count_bad()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
